// File: rtl/pcie_datalink_pkg.sv
// Shared definitions for the PCIe data-link layer blocks.
//   dllp_fc_t  : flow-control DLLP type byte (byte0) encodings for VC0
//   fc_type_e  : credit class index (posted, non-posted, completion)
//   rx_state_e : DLLP receive framing FSM states
package pcie_datalink_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h100B;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [7:0] {
        DllpInitFc1P    = 8'h40,
        DllpInitFc1Np   = 8'h50,
        DllpInitFc1Cpl  = 8'h60,
        DllpUpdateFcP   = 8'h80,
        DllpUpdateFcNp  = 8'h90,
        DllpUpdateFcCpl = 8'hA0,
        DllpInitFc2P    = 8'hC0,
        DllpInitFc2Np   = 8'hD0,
        DllpInitFc2Cpl  = 8'hE0
    } dllp_fc_t;

    typedef enum logic [1:0] {
        FcP   = 2'd0,
        FcNp  = 2'd1,
        FcCpl = 2'd2
    } fc_type_e;

    typedef enum logic [1:0] {
        StHdr,
        StCrc,
        StDrop
    } rx_state_e;

endpackage

// File: rtl/pcie_dllp_fc_receiver_if.sv
// AXI4-Stream style bus carrying received DLLPs (two beats per DLLP).
//   master : producer, drives tdata/tkeep/tvalid/tlast/tuser
//   slave  : consumer, drives tready
interface pcie_dllp_fc_receiver_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tready;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/pcie_datalink_crc.sv
// Combinational 16-bit DLLP CRC (polynomial 0x100B) over one 32-bit word.
// Bits are consumed LSB first starting at byte0 (data_i[7:0]).
//   data_i    : DLLP bytes 0-3
//   crc_in_i  : seed value
//   crc_out_o : CRC register after all 32 bits
module pcie_datalink_crc
    import pcie_datalink_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [15:0] crc_in_i,
    output logic [15:0] crc_out_o
);
    logic [15:0] crc_v;
    logic        fb;

    always_comb begin
        crc_v = crc_in_i;
        fb    = 1'b0;
        for (int i = 0; i < 32; i++) begin
            fb    = crc_v[15] ^ data_i[i];
            crc_v = {crc_v[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
        crc_out_o = crc_v;
    end
endmodule

// File: rtl/pcie_dllp_fc_receiver.sv
// Receives flow-control DLLPs, checks their CRC and tracks the link partner's
// credit limits through FC_INIT1 / FC_INIT2 / UpdateFC.
//   clk_i, rst_ni        : clock, async active-low reset
//   s_axis               : inbound DLLP stream (beat A = bytes 0-3, beat B = CRC)
//   clear_fc_i           : synchronous clear of all flow-control state
//   fc1/fc2_values_stored_o : sticky init-progress flags
//   update_fc_o          : one-cycle pulse per accepted UpdateFC
//   hdr_fc_*_o/data_fc_*_o : partner credit limits per class
//   crc_err_o            : one-cycle pulse per DLLP dropped for bad CRC
module pcie_dllp_fc_receiver
    import pcie_datalink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    pcie_dllp_fc_receiver_if.slave s_axis,
    input  logic                   clear_fc_i,
    output logic                   fc1_values_stored_o,
    output logic                   fc2_values_stored_o,
    output logic                   update_fc_o,
    output logic [7:0]             hdr_fc_p_o,
    output logic [7:0]             hdr_fc_np_o,
    output logic [7:0]             hdr_fc_cpl_o,
    output logic [11:0]            data_fc_p_o,
    output logic [11:0]            data_fc_np_o,
    output logic [11:0]            data_fc_cpl_o,
    output logic                   crc_err_o
);
    rx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] beat_a_q, beat_a_d;
    logic [2:0]            recorded_q, recorded_d;
    logic [2:0][7:0]       hdr_q, hdr_d;
    logic [2:0][11:0]      data_q, data_d;
    logic                  fc1_q, fc1_d, fc2_q, fc2_d;
    logic                  update_q, update_d, crc_err_q, crc_err_d;
    logic                  tready_q;

    logic [15:0] crc_out;
    logic        beat, crc_ok, commit;
    logic        is_init, is_init2, is_update;
    fc_type_e    fc_idx;
    logic [7:0]  hdr_fc;
    logic [11:0] data_fc;

    logic [KEEP_WIDTH-1:0] unused_tkeep;
    logic [USER_WIDTH-1:0] unused_tuser;
    logic [3:0]            unused_fields;
    assign unused_tkeep  = s_axis.tkeep;
    assign unused_tuser  = s_axis.tuser;
    assign unused_fields = {beat_a_q[15:14], beat_a_q[21:20]};

    pcie_datalink_crc u_crc (
        .data_i    (beat_a_q[31:0]),
        .crc_in_i  (CRC16_INIT),
        .crc_out_o (crc_out)
    );

    assign beat    = s_axis.tvalid & tready_q;
    assign crc_ok  = (s_axis.tdata[15:0] == ~crc_out);
    assign hdr_fc  = {beat_a_q[13:8], beat_a_q[23:22]};
    assign data_fc = {beat_a_q[19:16], beat_a_q[31:24]};

    // Type decode; non-VC0 and unknown types fall through as no-ops.
    always_comb begin
        is_init   = 1'b0;
        is_init2  = 1'b0;
        is_update = 1'b0;
        fc_idx    = FcP;
        case (dllp_fc_t'(beat_a_q[7:0]))
            DllpInitFc1P:    begin is_init = 1'b1; fc_idx = FcP;   end
            DllpInitFc1Np:   begin is_init = 1'b1; fc_idx = FcNp;  end
            DllpInitFc1Cpl:  begin is_init = 1'b1; fc_idx = FcCpl; end
            DllpInitFc2P:    begin is_init = 1'b1; is_init2 = 1'b1; fc_idx = FcP;   end
            DllpInitFc2Np:   begin is_init = 1'b1; is_init2 = 1'b1; fc_idx = FcNp;  end
            DllpInitFc2Cpl:  begin is_init = 1'b1; is_init2 = 1'b1; fc_idx = FcCpl; end
            DllpUpdateFcP:   begin is_update = 1'b1; fc_idx = FcP;   end
            DllpUpdateFcNp:  begin is_update = 1'b1; fc_idx = FcNp;  end
            DllpUpdateFcCpl: begin is_update = 1'b1; fc_idx = FcCpl; end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        beat_a_d   = beat_a_q;
        recorded_d = recorded_q;
        hdr_d      = hdr_q;
        data_d     = data_q;
        // Flag follows recording by one cycle.
        fc1_d      = fc1_q | (&recorded_q);
        fc2_d      = fc2_q;
        update_d   = 1'b0;
        crc_err_d  = 1'b0;
        commit     = 1'b0;

        case (state_q)
            StHdr: begin
                if (beat && !s_axis.tlast) begin
                    beat_a_d = s_axis.tdata;
                    state_d  = StCrc;
                end
            end
            StCrc: begin
                if (beat) begin
                    if (s_axis.tlast) begin
                        state_d   = StHdr;
                        commit    = crc_ok;
                        crc_err_d = ~crc_ok;
                    end else begin
                        state_d = StDrop;
                    end
                end
            end
            StDrop: begin
                if (beat && s_axis.tlast) state_d = StHdr;
            end
            default: state_d = StHdr;
        endcase

        if (commit) begin
            if (is_init && !recorded_q[fc_idx]) begin
                hdr_d[fc_idx]      = hdr_fc;
                data_d[fc_idx]     = data_fc;
                recorded_d[fc_idx] = 1'b1;
            end
            if (is_update && fc1_q) begin
                hdr_d[fc_idx]  = hdr_fc;
                data_d[fc_idx] = data_fc;
                update_d       = 1'b1;
            end
            if ((is_init2 || is_update) && fc1_q) fc2_d = 1'b1;
        end

        if (clear_fc_i) begin
            state_d    = StHdr;
            recorded_d = '0;
            hdr_d      = '0;
            data_d     = '0;
            fc1_d      = 1'b0;
            fc2_d      = 1'b0;
            update_d   = 1'b0;
            crc_err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StHdr;
            beat_a_q   <= '0;
            recorded_q <= '0;
            hdr_q      <= '0;
            data_q     <= '0;
            fc1_q      <= 1'b0;
            fc2_q      <= 1'b0;
            update_q   <= 1'b0;
            crc_err_q  <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_a_q   <= beat_a_d;
            recorded_q <= recorded_d;
            hdr_q      <= hdr_d;
            data_q     <= data_d;
            fc1_q      <= fc1_d;
            fc2_q      <= fc2_d;
            update_q   <= update_d;
            crc_err_q  <= crc_err_d;
            tready_q   <= 1'b1;
        end
    end

    assign s_axis.tready       = tready_q;
    assign fc1_values_stored_o = fc1_q;
    assign fc2_values_stored_o = fc2_q;
    assign update_fc_o         = update_q;
    assign crc_err_o           = crc_err_q;
    assign hdr_fc_p_o          = hdr_q[FcP];
    assign hdr_fc_np_o         = hdr_q[FcNp];
    assign hdr_fc_cpl_o        = hdr_q[FcCpl];
    assign data_fc_p_o         = data_q[FcP];
    assign data_fc_np_o        = data_q[FcNp];
    assign data_fc_cpl_o       = data_q[FcCpl];
endmodule

// File: tb/tb_pcie_dllp_fc_receiver.sv
// Directed bench for pcie_dllp_fc_receiver; per-DLLP pulse expectations go
// through a scoreboard queue, state checks are immediate.
module tb_pcie_dllp_fc_receiver;

    logic clk = 1'b0;
    logic rst_n;
    logic clear_fc;
    logic fc1, fc2, upd, crc_err;
    logic [7:0]  hdr_p, hdr_np, hdr_cpl;
    logic [11:0] data_p, data_np, data_cpl;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        logic err;
        logic upd;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    pcie_dllp_fc_receiver_if #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3)) s_axis ();

    pcie_dllp_fc_receiver #(.DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(3)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .s_axis              (s_axis),
        .clear_fc_i          (clear_fc),
        .fc1_values_stored_o (fc1),
        .fc2_values_stored_o (fc2),
        .update_fc_o         (upd),
        .hdr_fc_p_o          (hdr_p),
        .hdr_fc_np_o         (hdr_np),
        .hdr_fc_cpl_o        (hdr_cpl),
        .data_fc_p_o         (data_p),
        .data_fc_np_o        (data_np),
        .data_fc_cpl_o       (data_cpl),
        .crc_err_o           (crc_err)
    );

    // Reference DLLP CRC: poly 0x100B, seed all-ones, byte0 LSB first.
    function automatic logic [15:0] ref_crc(input logic [31:0] w);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < 32; i++) begin
            if (c[15] != w[i]) c = (c << 1) ^ 16'h100B;
            else               c = c << 1;
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [3:0] k, input logic last);
        s_axis.tdata  = d;
        s_axis.tkeep  = k;
        s_axis.tlast  = last;
        s_axis.tuser  = 3'($urandom_range(0, 7));
        s_axis.tvalid = 1'b1;
    endtask

    task automatic sb_pop_check(input string tag);
        exp_t e;
        n_asserts++;
        assert (sb_q.size() > 0)
        else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected entry", tag);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_crc_err"}, 32'(crc_err), 32'(e.err));
            check({tag, "_update"}, 32'(upd), 32'(e.upd));
        end
    endtask

    // Two-beat DLLP; returns one cycle after beat B was accepted.
    task automatic send_dllp(input string tag, input logic [7:0] b0, input logic [7:0] hdr,
                             input logic [11:0] dat, input logic flip, input logic clr,
                             input logic exp_err, input logic exp_upd);
        logic [31:0] word;
        logic [15:0] crc;
        word = {dat[7:0], hdr[1:0], 2'b00, dat[11:8], 2'b00, hdr[7:2], b0};
        crc  = ~ref_crc(word) ^ {15'd0, flip};
        @(negedge clk);
        drive(word, 4'hF, 1'b0);
        @(negedge clk);
        drive({16'h0000, crc}, 4'h3, 1'b1);
        clear_fc = clr;
        sb_q.push_back('{err: exp_err, upd: exp_upd});
        @(posedge clk);
        #1;
        sb_pop_check(tag);
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        clear_fc      = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_pulse_end"}, 32'({crc_err, upd}), 32'h0);
    endtask

    initial begin
        rst_n         = 1'b1;
        clear_fc      = 1'b0;
        s_axis.tdata  = '0;
        s_axis.tkeep  = '0;
        s_axis.tlast  = 1'b0;
        s_axis.tuser  = '0;
        s_axis.tvalid = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tready", 32'(s_axis.tready), 32'h0);
        check("rst_flags", 32'({fc1, fc2, upd, crc_err}), 32'h0);
        check("rst_hdr", 32'({hdr_p, hdr_np, hdr_cpl}), 32'h0);
        check("rst_data", 32'({data_p, data_np}) | 32'(data_cpl), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_up", 32'(s_axis.tready), 32'h1);

        // Bad CRC on InitFC1 P: error pulse, nothing recorded.
        send_dllp("bad_crc", 8'h40, 8'h20, 12'h010, 1'b1, 1'b0, 1'b1, 1'b0);
        check("bad_crc_hdr_p", 32'(hdr_p), 32'h0);
        check("bad_crc_data_p", 32'(data_p), 32'h0);

        // UpdateFC before FC1 done is ignored.
        send_dllp("early_upd", 8'hA0, 8'h40, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        check("early_upd_hdr_cpl", 32'(hdr_cpl), 32'h0);

        // Three-beat packet is dropped silently.
        @(negedge clk);
        drive(32'h0102_0340, 4'hF, 1'b0);
        @(negedge clk);
        drive(32'h0000_FFFF, 4'hF, 1'b0);
        @(negedge clk);
        drive(32'h0000_1234, 4'h3, 1'b1);
        @(posedge clk);
        #1;
        check("drop_crc_err", 32'(crc_err), 32'h0);
        @(negedge clk);
        s_axis.tvalid = 1'b0;

        send_dllp("init1_p", 8'h40, 8'h20, 12'h010, 1'b0, 1'b0, 1'b0, 1'b0);
        check("init1_p_hdr", 32'(hdr_p), 32'h20);
        check("init1_p_data", 32'(data_p), 32'h010);
        send_dllp("init1_np", 8'h50, 8'h11, 12'h0A5, 1'b0, 1'b0, 1'b0, 1'b0);
        check("init1_np_hdr", 32'(hdr_np), 32'h11);
        check("fc1_partial", 32'(fc1), 32'h0);
        send_dllp("init1_cpl", 8'h60, 8'h33, 12'h7FF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fc1_done", 32'(fc1), 32'h1);
        check("init1_cpl_data", 32'(data_cpl), 32'h7FF);
        check("fc2_not_yet", 32'(fc2), 32'h0);

        // Re-init of a recorded type leaves limits alone.
        send_dllp("reinit_p", 8'h40, 8'h55, 12'h321, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reinit_p_hdr", 32'(hdr_p), 32'h20);
        // VC1 and unknown types are discarded without error.
        send_dllp("vc1_upd", 8'h81, 8'h66, 12'h066, 1'b0, 1'b0, 1'b0, 1'b0);
        check("vc1_hdr_p", 32'(hdr_p), 32'h20);
        send_dllp("unknown", 8'h00, 8'h01, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0);
        check("unknown_fc2", 32'(fc2), 32'h0);

        send_dllp("init2_np", 8'hD0, 8'h77, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0);
        check("fc2_set", 32'(fc2), 32'h1);
        check("init2_np_hdr", 32'(hdr_np), 32'h11);
        check("init2_np_data", 32'(data_np), 32'h0A5);

        send_dllp("upd_cpl", 8'hA0, 8'h40, 12'h200, 1'b0, 1'b0, 1'b0, 1'b1);
        check("upd_cpl_hdr", 32'(hdr_cpl), 32'h40);
        check("upd_cpl_data", 32'(data_cpl), 32'h200);
        check("upd_p_kept", 32'(data_p), 32'h010);

        // Clear coincident with a valid UpdateFC beat B wins.
        send_dllp("clear", 8'h80, 8'h99, 12'h999, 1'b0, 1'b1, 1'b0, 1'b0);
        check("clear_flags", 32'({fc1, fc2}), 32'h0);
        check("clear_hdr", 32'({hdr_p, hdr_np, hdr_cpl}), 32'h0);
        check("clear_data", 32'({data_p, data_np}) | 32'(data_cpl), 32'h0);
        send_dllp("post_clear", 8'h40, 8'h21, 12'h0AB, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_clear_hdr_p", 32'(hdr_p), 32'h21);
        check("post_clear_fc1", 32'(fc1), 32'h0);

        // Reset mid-DLLP discards the partial packet.
        @(negedge clk);
        drive(32'h0000_0050, 4'hF, 1'b0);
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        rst_n         = 1'b0;
        #1;
        check("midrst_hdr_p", 32'(hdr_p), 32'h0);
        check("midrst_tready", 32'(s_axis.tready), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_dllp("after_rst", 8'h50, 8'h3C, 12'h456, 1'b0, 1'b0, 1'b0, 1'b0);
        check("after_rst_hdr_np", 32'(hdr_np), 32'h3C);
        check("after_rst_data_np", 32'(data_np), 32'h456);

        check("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_dllp_fc_receiver.md
PCIE_DLLP_FC_RECEIVER -- requirements
Module: pcie_dllp_fc_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of the inbound DLLP stream; only 32 is supported.
REQ-002 Parameter KEEP_WIDTH, default DATA_WIDTH/8: byte-enable width.
REQ-003 Parameter USER_WIDTH, default 3: tuser width; tuser is ignored.
REQ-004 Port clk_i, in, 1: single clock.
REQ-005 Port rst_ni, in, 1: reset, asynchronous and active-low.
REQ-006 Ports s_axis_tdata/tkeep/tvalid/tlast/tuser, in, DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH: received DLLP stream; byte0 is tdata[7:0].
REQ-007 Port s_axis_tready, out, 1: sink ready.
REQ-008 Port clear_fc_i, in, 1: synchronous clear of all stored flow-control state, used when the link goes DL_Inactive.
REQ-009 Port fc1_values_stored_o, out, 1: InitFC1 or InitFC2 received for all of P, NP and Cpl; feeds fc1_values_stored_i on the flow-control init transmitter.
REQ-010 Port fc2_values_stored_o, out, 1: FC_INIT2 complete; feeds fc2_values_stored_i.
REQ-011 Port update_fc_o, out, 1: one-cycle pulse per accepted UpdateFC; feeds update_fc_i.
REQ-012 Ports hdr_fc_p_o, hdr_fc_np_o, hdr_fc_cpl_o, out, 8 each: partner header credit limits.
REQ-013 Ports data_fc_p_o, data_fc_np_o, data_fc_cpl_o, out, 12 each: partner data credit limits.
REQ-014 Port crc_err_o, out, 1: one-cycle pulse when a DLLP is discarded for a CRC mismatch.

Function
REQ-015 Each DLLP is two beats.
- Beat A: tkeep=4'hF, tlast=0, carrying DLLP bytes 0-3.
- Beat B: tkeep=4'h3, tlast=1, carrying the CRC in tdata[15:0].
REQ-016 s_axis_tready SHALL be 1 whenever the block is out of reset; the block never backpressures.
REQ-017 The FSM states are:
- ST_HDR: waits for beat A. On a beat with tlast=0, it registers the beat and goes to ST_CRC. On a beat with tlast=1, it goes to nothing and the beat is dropped silently.
- ST_CRC: waits for beat B. On tlast=1, it checks and commits, then returns to ST_HDR. On tlast=0, it goes to ST_DROP.
- ST_DROP: discards beats until one with tlast=1, then returns to ST_HDR.
REQ-018 The CRC check is computed combinationally by pcie_datalink_crc with crcIn all-ones over the registered beat A. The DLLP is valid when tdata[15:0] of beat B equals the bitwise inverse of crc_out; otherwise crc_err_o pulses and no state changes.
REQ-019 Type byte0 decode is as follows, with byte0[2:0] = VC ID.
- InitFC1: P=8'h40, NP=8'h50, Cpl=8'h60.
- InitFC2: P=8'hC0, NP=8'hD0, Cpl=8'hE0.
- UpdateFC: P=8'h80, NP=8'h90, Cpl=8'hA0.
- A DLLP with VC ID other than 0 or any other type is discarded without error.
REQ-020 Field extraction:
- HdrFC = {byte1[5:0], byte2[7:6]}.
- DataFC = {byte2[3:0], byte3}.
REQ-021 A valid InitFC1 or InitFC2 for a type not yet recorded latches HdrFC/DataFC for that type and sets its recorded bit. Later Init DLLPs of a recorded type SHALL NOT alter the credit limits.
REQ-022 fc1_values_stored_o is set, sticky, in the cycle after the third type becomes recorded.
REQ-023 fc2_values_stored_o is set, sticky, on a valid InitFC2 or UpdateFC of any type accepted while fc1_values_stored_o=1.
REQ-024 A valid UpdateFC accepted while fc1_values_stored_o=1 overwrites that type's limits and pulses update_fc_o for exactly one cycle. An UpdateFC received earlier is discarded.
REQ-025 Outputs are registered; commit latency is one clock after beat B is accepted.
REQ-026 clear_fc_i=1 clears all recorded bits, both sticky flags and all credit limits, and forces ST_HDR. clear_fc_i wins over a simultaneous commit.

Reset
REQ-027 While rst_ni=0, all outputs are 0, credit limits are 0, recorded bits are 0 and the FSM is in ST_HDR; s_axis_tready deasserts.
REQ-028 Reset asserted mid-DLLP discards the partial packet; after release, the block restarts in ST_HDR.

Structure
REQ-029 The DLLP type encodings, dllp_fc_t and the FSM enum belong in pcie_datalink_pkg.
REQ-030 The one sub-module is pcie_datalink_crc (existing).

Verification
REQ-031 Send InitFC1 P (Hdr=8'h20, Data=12'h010), then NP, then Cpl, all with correct CRC -> fc1_values_stored_o=1 one cycle after the Cpl beat B, and hdr_fc_p_o=8'h20, data_fc_p_o=12'h010.
REQ-032 Send InitFC1_P with CRC bit 0 flipped -> crc_err_o pulses once, and the P recorded bit and limits stay 0.
REQ-033 After FC1 is complete, send InitFC2_NP -> fc2_values_stored_o=1, and the NP limits are unchanged.
REQ-034 After FC1 is complete, send UpdateFC_Cpl with Hdr=8'h40 -> update_fc_o high for one cycle and hdr_fc_cpl_o=8'h40. Before FC1 is complete, the same DLLP produces no pulse.
REQ-035 Send a three-beat packet, then a valid InitFC1_P -> the first packet is dropped with no error, and the second is recorded.
REQ-036 Assert clear_fc_i in the same cycle as a valid beat B -> all flags and limits are 0 on the next cycle.
